crc24a_axis_stall_detect: RTL and testbench
===========================================

# crc24a_axis_stall_detect

Per-channel AXI-Stream stall detector for the crc24a HLS core. It watches the tvalid/tready pair of each AXI-Stream port of crc24a: channel 0 is the data input stream, channel 1 is the CRC output stream. It produces the registered `axis_block_sigs` vector that feeds the crc24a deadlock monitor directly. It also latches which channel blocked first, for debug readout.

## Interface

Parameters:
- `NUM_CH`, 2: number of monitored AXI-Stream channels.
- `CNT_W`, 16: stall counter width. Requirement: `THRESH` < 2^`CNT_W`.
- `THRESH`, 1024: consecutive stalled cycles required before a channel is flagged. Must be ≥ 1.
- `IS_OUT`, 2'b10: per-channel direction mask. 1 = output stream of crc24a; 0 = input stream.

Ports:
- `clock`, input, 1: the single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `axis_tvalid`, input, `NUM_CH`: tvalid of each monitored channel.
- `axis_tready`, input, `NUM_CH`: tready of each monitored channel.
- `clear`, input, 1: one-cycle pulse that clears the sticky first-block capture.
- `axis_block_sigs`, output, `NUM_CH`: per-channel blocked flag, registered. Feeds the deadlock monitor.
- `first_block_valid`, output, 1: sticky; set when any channel first blocks.
- `first_block_ch`, output, clog2(`NUM_CH`): index of the first channel that blocked.

## Operation

- Stall condition per channel c:
  - Output channel (`IS_OUT[c]`=1): `tvalid & ~tready`. crc24a has data and downstream refuses it.
  - Input channel (`IS_OUT[c]`=0): `tready & ~tvalid`. crc24a wants data and upstream is empty.
- Stall counter, one per channel, per cycle:
  - Stall condition true: `cnt` increments, saturating at `THRESH`.
  - Any other cycle (transfer, or fully idle with both signals low): `cnt` returns to 0.
- `axis_block_sigs[c]` next value = (`cnt_next[c]` == `THRESH`), registered.
- First-block capture:
  - Capture happens in any cycle where `first_block_valid`=0 and some `axis_block_sigs` next bit is 1.
  - On capture, `first_block_valid` is set and `first_block_ch` takes the lowest such index.
  - Both outputs hold their value until `clear` or `reset`.
- `clear` has priority over a capture in the same cycle. If a block persists, the capture re-occurs on the following cycle.
- `clear` does not affect the counters or `axis_block_sigs`.
- No internal state machine beyond the counters. Each channel is independent.

## Timing

- Reset values: all counters 0, `axis_block_sigs`=0, `first_block_valid`=0, `first_block_ch`=0.
- Assertion latency:
  - Stall condition true on cycles 0 … `THRESH`-1 consecutively: `axis_block_sigs[c]` is high from cycle `THRESH`.
  - `THRESH`=1: flag is high the cycle after the first stall cycle.
- Deassertion: first non-stall cycle k drops the flag at cycle k+1.
- Re-stall after deassertion: a full new `THRESH`-cycle count is needed. There is no hysteresis.
- Saturation: `cnt` holds at `THRESH` while the stall continues. It never wraps, and the flag stays high.
- Simultaneous thresholds on several channels in one cycle: all flags assert together; `first_block_ch` = lowest index.
- Reset asserted mid-stall: counters and flags go to 0 on the next edge. Counting restarts from 0 on the first cycle after reset deasserts.
- `first_block_valid` rises in the same cycle as the triggering `axis_block_sigs` bit.

## Structure

- Shared package `crc24a_hls_monitor_pkg` holds:
  - `CRC24A_NUM_AXIS` = 2.
  - Channel indices `CH_DATA_IN` = 0 and `CH_CRC_OUT` = 1.
  - `CRC24A_AXIS_DIR` = 2'b10.
  - `CRC24A_STALL_THRESH` default.
- Sub-module `crc24a_axis_stall_ch`, instantiated `NUM_CH` times.
  - Contents: one direction select, one saturating counter and the registered flag.
  - Parameters: `CNT_W`, `THRESH`, `IS_OUT`.
- The top level holds only the generate loop, the lowest-index priority encoder and the sticky capture registers.

## Test plan

All scenarios use `THRESH`=4.
- Reset check: hold `reset` for 3 cycles with random tvalid/tready. Required: all outputs 0 during reset and on the first cycle after it.
- Output-stall threshold: ch1 `tvalid`=1, `tready`=0 for 4 cycles from cycle 0. Required:
  - `axis_block_sigs`=2'b10 at cycle 4.
  - `first_block_valid`=1 and `first_block_ch`=1 at cycle 4.
  - Raising `tready` at cycle 6 drops the flag at cycle 7.
- Input stall with break: ch0 `tready`=1, `tvalid`=0 for 3 cycles, one transfer cycle, then 4 more stall cycles. Required: no flag through the first 4 cycles; flag high exactly 4 cycles after the stall resumes.
- Simultaneous: both channels start stalling on the same cycle. Required: `axis_block_sigs`=2'b11 together and `first_block_ch`=0.
- Clear versus persistent block: pulse `clear` while ch1 stays blocked. Required:
  - `first_block_valid`=0 for exactly one cycle, then 1 again with `first_block_ch`=1.
  - `axis_block_sigs` is unchanged throughout.
- Reset mid-stall plus saturation:
  - Stall ch1 for 20 cycles. Required: flag stays high and no wrap.
  - Assert `reset` at cycle 10. Required: flag is 0 next cycle and re-asserts 4 cycles after reset deasserts.

Source files
------------

// File: rtl/crc24a_hls_monitor_pkg.sv
// Purpose: shared constants and helpers for the crc24a HLS stream monitors.
// Latency: n/a (package only).
// Backpressure: n/a; defines the per-direction stall condition used by the detectors.
package crc24a_hls_monitor_pkg;

    localparam int CRC24A_NUM_AXIS = 2;

    // Channel indices into the monitored stream vectors.
    localparam int CH_DATA_IN = 0;
    localparam int CH_CRC_OUT = 1;

    // 1 = stream driven by crc24a (output), 0 = stream consumed by crc24a (input).
    localparam logic [CRC24A_NUM_AXIS-1:0] CRC24A_AXIS_DIR = 2'b10;

    localparam int CRC24A_STALL_THRESH = 1024;

    // An output stalls when crc24a offers data that is refused; an input stalls
    // when crc24a is ready but nothing is offered.
    function automatic logic stall_cond(input logic is_out,
                                        input logic tvalid,
                                        input logic tready);
        return is_out ? (tvalid & ~tready) : (tready & ~tvalid);
    endfunction

endpackage

// File: rtl/crc24a_axis_stall_ch.sv
// Purpose: single-channel stall counter with registered blocked flag.
// Latency: flag rises THRESH cycles after the first stall cycle, drops 1 cycle after a non-stall cycle.
// Backpressure: observe-only; never drives tvalid/tready.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   tvalid, tready      observed handshake pair of this channel
//   block_next          combinational next value of the flag (for first-block capture)
//   block               registered blocked flag
module crc24a_axis_stall_ch
    import crc24a_hls_monitor_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int THRESH = 1024,
    parameter bit IS_OUT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic tvalid,
    input  logic tready,
    output logic block_next,
    output logic block
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stall;

    always_comb begin
        stall    = stall_cond(IS_OUT, tvalid, tready);
        cnt_next = '0;
        if (stall) begin
            // Saturate so a long stall never wraps and drops the flag.
            cnt_next = (cnt == THRESH_C) ? cnt : cnt + CNT_W'(1);
        end
        block_next = (cnt_next == THRESH_C);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            block <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            block <= block_next;
        end
    end

endmodule

// File: rtl/crc24a_axis_stall_detect.sv
// Purpose: per-channel AXI-Stream stall detector for crc24a with sticky first-block capture.
// Latency: block flags and first-block capture update on the same registered edge.
// Backpressure: observe-only; clear wins over a same-cycle capture, which then recurs next cycle.
//
// Ports:
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   axis_tvalid, axis_tready        handshake pairs of the monitored streams
//   clear                           one-cycle pulse clearing the sticky capture
//   axis_block_sigs                 registered per-channel blocked flags (to deadlock monitor)
//   first_block_valid/_ch           sticky capture of the first (lowest-index) blocked channel
module crc24a_axis_stall_detect
    import crc24a_hls_monitor_pkg::*;
#(
    parameter  int                NUM_CH = CRC24A_NUM_AXIS,
    parameter  int                CNT_W  = 16,
    parameter  int                THRESH = CRC24A_STALL_THRESH,
    parameter  logic [NUM_CH-1:0] IS_OUT = CRC24A_AXIS_DIR,
    localparam int                CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] axis_tvalid,
    input  logic [NUM_CH-1:0] axis_tready,
    input  logic              clear,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              first_block_valid,
    output logic [CH_W-1:0]   first_block_ch
);

    logic [NUM_CH-1:0] block_next;
    logic [CH_W-1:0]   low_ch;
    logic              any_block;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        crc24a_axis_stall_ch #(
            .CNT_W  (CNT_W),
            .THRESH (THRESH),
            .IS_OUT (IS_OUT[c])
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .tvalid     (axis_tvalid[c]),
            .tready     (axis_tready[c]),
            .block_next (block_next[c]),
            .block      (axis_block_sigs[c])
        );
    end

    // Lowest-index priority encoder: scan downward so the lowest hit wins.
    always_comb begin
        low_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (block_next[i]) begin
                low_ch = CH_W'(i);
            end
        end
        any_block = |block_next;
    end

    // Capture uses the next flag values so valid rises with the triggering flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_block_valid <= 1'b0;
            first_block_ch    <= CH_W'(CH_DATA_IN);
        end else if (clear) begin
            first_block_valid <= 1'b0;
        end else if (!first_block_valid && any_block) begin
            first_block_valid <= 1'b1;
            first_block_ch    <= low_ch;
        end
    end

endmodule

// File: tb/tb_crc24a_axis_stall_detect.sv
// Purpose: directed self-checking bench for crc24a_axis_stall_detect at THRESH=4.
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_crc24a_axis_stall_detect;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 3;   // narrow counter so a missing saturation would wrap
    localparam int THRESH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] axis_tvalid;
    logic [NUM_CH-1:0] axis_tready;
    logic              clear;
    logic [NUM_CH-1:0] axis_block_sigs;
    logic              first_block_valid;
    logic [0:0]        first_block_ch;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    crc24a_axis_stall_detect #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .THRESH (THRESH),
        .IS_OUT (2'b10)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .axis_tvalid       (axis_tvalid),
        .axis_tready       (axis_tready),
        .clear             (clear),
        .axis_block_sigs   (axis_block_sigs),
        .first_block_valid (first_block_valid),
        .first_block_ch    (first_block_ch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One idle cycle with clear pulsed; capture must be empty afterwards.
    task automatic flush(input string tag);
        axis_tvalid = '0;
        axis_tready = '0;
        clear       = 1'b1;
        tick();
        clear = 1'b0;
        chk(tag, {31'd0, first_block_valid}, 32'd0);
    endtask

    initial begin
        logic [1:0] exp_blk;
        logic       exp_v;

        reset       = 1'b1;
        clear       = 1'b0;
        axis_tvalid = '0;
        axis_tready = '0;

        // Reset held 3 cycles with random handshakes.
        for (int i = 0; i < 3; i++) begin
            axis_tvalid = 2'($urandom);
            axis_tready = 2'($urandom);
            tick();
            chk("rst_blk", {30'd0, axis_block_sigs}, 32'd0);
            chk("rst_fv",  {31'd0, first_block_valid}, 32'd0);
            chk("rst_fch", {31'd0, first_block_ch}, 32'd0);
        end
        reset       = 1'b0;
        axis_tvalid = '0;
        axis_tready = '0;
        tick();
        chk("post_rst_blk", {30'd0, axis_block_sigs}, 32'd0);
        chk("post_rst_fv",  {31'd0, first_block_valid}, 32'd0);
        chk("post_rst_fch", {31'd0, first_block_ch}, 32'd0);

        // Output stall on ch1, tready raised at cycle 6.
        for (int t = 0; t < 8; t++) begin
            axis_tvalid = 2'b10;
            axis_tready = (t >= 6) ? 2'b10 : 2'b00;
            exp_blk = (t >= 4 && t <= 6) ? 2'b10 : 2'b00;
            chk("ostall_blk", {30'd0, axis_block_sigs}, {30'd0, exp_blk});
            chk("ostall_fv", {31'd0, first_block_valid}, {31'd0, (t >= 4)});
            if (t >= 4) chk("ostall_fch", {31'd0, first_block_ch}, 32'd1);
            tick();
        end
        flush("ostall_clr");

        // Input stall on ch0: 3 stalls, transfer, 4 stalls.
        for (int t = 0; t < 9; t++) begin
            axis_tready = 2'b01;
            axis_tvalid = (t == 3) ? 2'b01 : 2'b00;
            exp_blk = (t == 8) ? 2'b01 : 2'b00;
            chk("istall_blk", {30'd0, axis_block_sigs}, {30'd0, exp_blk});
            if (t == 8) begin
                chk("istall_fv",  {31'd0, first_block_valid}, 32'd1);
                chk("istall_fch", {31'd0, first_block_ch}, 32'd0);
            end
            tick();
        end
        flush("istall_clr");

        // Both channels stall from the same cycle.
        for (int t = 0; t < 5; t++) begin
            axis_tvalid = 2'b10;
            axis_tready = 2'b01;
            exp_blk = (t == 4) ? 2'b11 : 2'b00;
            chk("simul_blk", {30'd0, axis_block_sigs}, {30'd0, exp_blk});
            if (t == 4) begin
                chk("simul_fv",  {31'd0, first_block_valid}, 32'd1);
                chk("simul_fch", {31'd0, first_block_ch}, 32'd0);
            end
            tick();
        end
        flush("simul_clr");

        // Clear while ch1 stays blocked; 20-cycle stall also exercises saturation.
        for (int t = 0; t < 20; t++) begin
            axis_tvalid = 2'b10;
            axis_tready = 2'b00;
            clear       = (t == 5);
            exp_blk = (t >= 4) ? 2'b10 : 2'b00;
            exp_v   = (t >= 4) && (t != 6);
            chk("clr_blk", {30'd0, axis_block_sigs}, {30'd0, exp_blk});
            chk("clr_fv",  {31'd0, first_block_valid}, {31'd0, exp_v});
            if (exp_v) chk("clr_fch", {31'd0, first_block_ch}, 32'd1);
            tick();
        end
        flush("sat_clr");

        // Reset pulse at cycle 10 of a 20-cycle ch1 stall.
        for (int t = 0; t < 20; t++) begin
            axis_tvalid = 2'b10;
            axis_tready = 2'b00;
            reset       = (t == 10);
            exp_v   = (t >= 4 && t <= 10) || (t >= 15);
            exp_blk = exp_v ? 2'b10 : 2'b00;
            chk("mrst_blk", {30'd0, axis_block_sigs}, {30'd0, exp_blk});
            chk("mrst_fv",  {31'd0, first_block_valid}, {31'd0, exp_v});
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
